// File: rtl/jt49_dcrm_mc_pkg.sv
// Shared definitions for the multi-channel DC-removal filter:
// sweep FSM encoding, channel index width and integrator width helper.
package jt49_dcrm_mc_pkg;

    // Sweep FSM: IDLE waits for a sample strobe, RUN walks the channels.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dcrm_state_t;

    // Channel index width; up to 16 channels.
    localparam int CH_IDX_W = 4;

    // Integrator width: sample width, one bit for the signed difference,
    // one guard bit for the step, plus the fractional bits.
    function automatic int calc_iw(input int dw, input int fw);
        return dw + 2 + fw;
    endfunction

endpackage

// File: rtl/jt49_dcrm_mc_core.sv
// Combinational per-sample datapath of the DC-removal filter.
// Takes one channel's sample and integrator state and produces the
// saturated output sample plus the next integrator/error-feedback state.
module jt49_dcrm_mc_core
    import jt49_dcrm_mc_pkg::*;
#(
    parameter int DW        = 8,
    parameter int FW        = 10,
    parameter int K         = 0,
    parameter int SIGNED_IN = 0,
    parameter int IW        = calc_iw(DW, FW)
) (
    input  logic [DW-1:0] din_c,
    input  logic [IW-1:0] integ,
    input  logic [FW-1:0] err,
    output logic [DW-1:0] y_sat,
    output logic [IW-1:0] integ_nx,
    output logic [FW-1:0] err_nx
);

    // Saturation limits for the difference and the integrator.
    localparam logic signed [DW+1:0] Y_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] Y_MIN = {3'b111, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]        D_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        D_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [IW-1:0]        I_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic [IW-1:0]        I_MIN = {1'b1, {(IW-1){1'b0}}};

    logic        [DW:0]    x_s;
    logic        [FW+DW:0] exact_s;
    logic        [DW:0]    q_s;
    logic signed [DW+1:0]  y_s;
    logic        [IW:0]    step_s;
    logic        [IW:0]    sum_s;

    // Sample extension, error-feedback rounding and output difference.
    // Only the low FW+DW+1 bits of integ+err matter for q, because q is
    // truncated to DW+1 bits; modular addition keeps those bits exact.
    always_comb begin
        x_s     = (SIGNED_IN != 0) ? {din_c[DW-1], din_c} : {1'b0, din_c};
        exact_s = integ[FW+DW:0] + {{(DW+1){1'b0}}, err};
        q_s     = exact_s[FW+DW:FW];
        y_s     = $signed({x_s[DW], x_s}) - $signed({q_s[DW], q_s});
        // exact - (q <<< FW) only keeps the fractional part of exact
        err_nx  = exact_s[FW-1:0];
    end

    // Clamp the difference to the signed output range.
    always_comb begin
        if (y_s > Y_MAX) begin
            y_sat = D_MAX;
        end else if (y_s < Y_MIN) begin
            y_sat = D_MIN;
        end else begin
            y_sat = y_s[DW-1:0];
        end
    end

    // Integrator update with the leak shift, saturating instead of wrapping.
    always_comb begin
        step_s = {{(FW+1){y_s[DW+1]}}, y_s} << (FW - K);
        sum_s  = {integ[IW-1], integ} + step_s;
        if (sum_s[IW] != sum_s[IW-1]) begin
            integ_nx = sum_s[IW] ? I_MIN : I_MAX;
        end else begin
            integ_nx = sum_s[IW-1:0];
        end
    end

endmodule

// File: rtl/jt49_dcrm_mc.sv
// Multi-channel DC-removal high-pass filter. A single datapath is shared
// by all channels: each sample strobe latches the inputs and starts a sweep
// that processes one channel per clock, keeping per-channel state in arrays.
module jt49_dcrm_mc
    import jt49_dcrm_mc_pkg::*;
#(
    parameter int CH        = 3,
    parameter int DW        = 8,
    parameter int FW        = 10,
    parameter int K         = 0,
    parameter int SIGNED_IN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [CH*DW-1:0] din,
    output logic [DW-1:0]    dout,
    output logic [3:0]       dout_ch,
    output logic             dout_valid,
    output logic             busy,
    output logic             ovf
);

    localparam int                    IW      = calc_iw(DW, FW);
    localparam logic [CH_IDX_W-1:0]   LAST_CH = CH_IDX_W'(CH - 1);

    dcrm_state_t         state_r;
    dcrm_state_t         state_nx;
    logic [CH_IDX_W-1:0] ch_r;
    logic [CH_IDX_W-1:0] ch_nx;
    logic                busy_r;
    logic                busy_nx;
    logic                ovf_r;
    logic [CH*DW-1:0]    din_l_r;
    logic [IW-1:0]       integ_r [CH];
    logic [FW-1:0]       err_r   [CH];

    logic [DW-1:0]       din_sel_s;
    logic [IW-1:0]       integ_sel_s;
    logic [FW-1:0]       err_sel_s;
    logic [DW-1:0]       y_sat_s;
    logic [IW-1:0]       integ_nx_s;
    logic [FW-1:0]       err_nx_s;

    logic [DW-1:0]       dout_r;
    logic [3:0]          dout_ch_r;
    logic                dout_valid_r;

    // Sweep sequencing: start on cen in IDLE, step channels in RUN.
    always_comb begin
        state_nx = state_r;
        ch_nx    = ch_r;
        busy_nx  = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (cen) begin
                    state_nx = ST_RUN;
                    ch_nx    = {CH_IDX_W{1'b0}};
                    busy_nx  = 1'b1;
                end else begin
                    busy_nx  = 1'b0;
                end
            end
            ST_RUN: begin
                if (ch_r == LAST_CH) begin
                    state_nx = ST_IDLE;
                    ch_nx    = {CH_IDX_W{1'b0}};
                    busy_nx  = 1'b0;
                end else begin
                    ch_nx    = ch_r + 4'd1;
                    busy_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                ch_nx    = {CH_IDX_W{1'b0}};
                busy_nx  = 1'b0;
            end
        endcase
    end

    // FSM state, channel counter and busy flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ch_r    <= {CH_IDX_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            ch_r    <= ch_nx;
            busy_r  <= busy_nx;
        end
    end

    // Snapshot of all channel inputs taken when a sweep starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_l_r <= {(CH*DW){1'b0}};
        end else if ((state_r == ST_IDLE) && cen) begin
            din_l_r <= din;
        end
    end

    // Route the current channel's sample and state into the shared datapath.
    always_comb begin
        din_sel_s   = {DW{1'b0}};
        integ_sel_s = {IW{1'b0}};
        err_sel_s   = {FW{1'b0}};
        for (int c = 0; c < CH; c++) begin
            if (ch_r == CH_IDX_W'(c)) begin
                din_sel_s   = din_l_r[c*DW +: DW];
                integ_sel_s = integ_r[c];
                err_sel_s   = err_r[c];
            end else begin
                din_sel_s   = din_sel_s;
                integ_sel_s = integ_sel_s;
                err_sel_s   = err_sel_s;
            end
        end
    end

    jt49_dcrm_mc_core #(
        .DW        (DW),
        .FW        (FW),
        .K         (K),
        .SIGNED_IN (SIGNED_IN),
        .IW        (IW)
    ) u_core (
        .din_c    (din_sel_s),
        .integ    (integ_sel_s),
        .err      (err_sel_s),
        .y_sat    (y_sat_s),
        .integ_nx (integ_nx_s),
        .err_nx   (err_nx_s)
    );

    // Per-channel integrator/error state; only the active channel moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                integ_r[c] <= {IW{1'b0}};
                err_r[c]   <= {FW{1'b0}};
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if ((state_r == ST_RUN) && (ch_r == CH_IDX_W'(c))) begin
                    integ_r[c] <= integ_nx_s;
                    err_r[c]   <= err_nx_s;
                end
            end
        end
    end

    // Sticky overrun: a strobe while a sweep is still running is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (cen && (state_r == ST_RUN)) begin
            ovf_r <= 1'b1;
        end
    end

    // Output sample registers; dout/dout_ch hold between sweeps.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r       <= {DW{1'b0}};
            dout_ch_r    <= 4'd0;
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= (state_r == ST_RUN);
            if (state_r == ST_RUN) begin
                dout_r    <= y_sat_s;
                dout_ch_r <= 4'(ch_r);
            end
        end
    end

    assign dout       = dout_r;
    assign dout_ch    = dout_ch_r;
    assign dout_valid = dout_valid_r;
    assign busy       = busy_r;
    assign ovf        = ovf_r;

endmodule
